load_unit: RTL
==============

# load_unit

Memory-read front end for the core's load instructions: accepts one load request (address + funct3), issues one or two word-aligned reads to the data-memory port with a valid/ready handshake, and gathers the response word(s). It then selects the addressed byte/halfword/word, including halfwords and words that straddle a word boundary. Finally it sign- or zero-extends the selected data to XLEN and returns it with a one-cycle result strobe. It sits directly upstream of the register-file write-back mux and contains the byte-lane select and extend step that feeds write-back.

## Interface
- XLEN, 32, data and address width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_addr  in  XLEN  byte address
- req_funct3  in  3  RV32I load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- mem_rd_valid  out  1  read command valid
- mem_rd_ready  in  1  memory accepts the read command
- mem_rd_addr  out  XLEN  word address, bits [1:0] always 00
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  XLEN  read data, little-endian word
- res_valid  out  1  one-cycle result strobe
- res_data  out  XLEN  extended load result
- res_err  out  1  illegal funct3, qualified by res_valid

## Operation
- FSM states: IDLE, RD0, WAIT0, RD1, WAIT1, DONE.
- req_ready = (state == IDLE) and reset_n high. A request is accepted on req_valid && req_ready. On accept, latch addr, funct3, off = addr[1:0], and size = 1/2/4 bytes.
- Illegal funct3: IDLE -> DONE. No memory access. res_data = 0, res_err = 1.
- Legal funct3: IDLE -> RD0. mem_rd_addr = {addr[31:2], 00}.
- Split condition: off + size > 4. Next word address = word0 + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
- Read command rule: mem_rd_valid = 1 in RD0/RD1 only. mem_rd_addr is held stable until mem_rd_ready. Advance RD0 -> WAIT0 or RD1 -> WAIT1 on mem_rd_valid && mem_rd_ready.
- WAIT0 transitions:
  - mem_rsp_valid, no split: capture word0, -> DONE.
  - mem_rsp_valid, split: capture word0, -> RD1.
- WAIT1 transitions: mem_rsp_valid: capture word1, -> DONE.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- Extraction:
  - Form the 64-bit value {word1, word0}; word1 = 0 when not split.
  - Shift right by 8*off and take the low 8*size bits.
  - LB/LH: sign-extend from bit 7/15. LBU/LHU: zero-extend. LW: no extension.
- DONE: res_valid = 1 for exactly one cycle, then -> IDLE. res_data/res_err are registered and valid only while res_valid = 1; otherwise both read 0.
- Results cannot be back-pressured.
- Reset (async, any state): state -> IDLE. Captured words, res_valid, res_data, res_err and mem_rd_valid -> 0. An in-flight read is abandoned and its late response is ignored.

## Timing
- Reset values: req_ready 0 while reset_n low, 1 after release; all other outputs 0.
- Aligned load with mem_rd_ready = 1 and response one cycle after the command:
  - accept at edge T; RD0 during T+1;
  - WAIT0 at T+2, rsp sampled;
  - res_valid during T+3.
- Split load: +2 cycles (RD1, WAIT1).
- Illegal funct3: res_valid in the cycle after accept.
- Each cycle of mem_rd_ready = 0 or mem_rsp_valid = 0 adds one cycle.
- req_ready returns to 1 the cycle after res_valid, so back-to-back requests are spaced by at least the latency.
- A response is never sampled in the same cycle as its command.

## Test plan
- LB at 0x103, word @0x100 = 0x8A00_0000 -> one read to 0x100; res_data 0xFFFF_FF8A, res_err 0, res_valid high exactly 1 cycle, 3 cycles after accept.
- LBU at 0x103, same data -> res_data 0x0000_008A; LHU at 0x102 -> 0x0000_8A00.
- LH at 0x203, @0x200 = 0x1122_3344, @0x204 = 0x5566_7788 -> reads 0x200 then 0x204; res_data 0xFFFF_8811; latency 5.
- LW at 0xFFFF_FFFE, @0xFFFF_FFFC = 0xAABB_CCDD, @0x0 = 0x1122_3344 -> second read address 0x0; res_data 0x3344_AABB.
- funct3 = 011 -> mem_rd_valid never asserted; next cycle res_valid = 1, res_err = 1, res_data 0.
- LW at 0x10, hold mem_rd_ready = 0 for 4 cycles -> mem_rd_valid/addr stable. Assert reset_n low in WAIT0 and release, then drive mem_rsp_valid -> no res_valid, outputs 0, req_ready 1, next LW completes correctly.

Source files
------------

// File: rtl/load_unit_if.sv
// Load request, data-memory read and result signals between the load unit and its surroundings.
// The unit takes the slave side; the core and memory take the master side.
interface load_unit_if;
   localparam int unsigned XLEN = 32;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic [2:0]      req_funct3;
   logic            mem_rd_valid;
   logic            mem_rd_ready;
   logic [XLEN-1:0] mem_rd_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic            res_valid;
   logic [XLEN-1:0] res_data;
   logic            res_err;

   modport slave (
      input  req_valid, req_addr, req_funct3, mem_rd_ready, mem_rsp_valid, mem_rsp_data,
      output req_ready, mem_rd_valid, mem_rd_addr, res_valid, res_data, res_err
   );

   modport master (
      output req_valid, req_addr, req_funct3, mem_rd_ready, mem_rsp_valid, mem_rsp_data,
      input  req_ready, mem_rd_valid, mem_rd_addr, res_valid, res_data, res_err
   );
endinterface

// File: rtl/load_unit.sv
// RV32I load front end: one or two word reads, byte-lane select across a word boundary,
// then sign/zero extension with a one-cycle result strobe.
module load_unit (
   input logic       clk,
   input logic       reset_n,
   load_unit_if.slave bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      off_q, off_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            split_q, split_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] word0_q, word0_d;
   logic [XLEN-1:0] word1_q, word1_d;
   logic [XLEN-1:0] rd_addr_q, rd_addr_d;
   logic            rd_valid_q, rd_valid_d;
   logic            res_valid_q, res_valid_d;
   logic [XLEN-1:0] res_data_q, res_data_d;
   logic            res_err_q, res_err_d;

   logic            legal;
   logic [2:0]      size;

   // Shift the two-word window down to the addressed byte, then extend per load type
   function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w0, input logic [XLEN-1:0] w1);
      logic [2*XLEN-1:0] wide;
      logic [XLEN-1:0]   sel;
      wide = {w1, w0} >> {off, 3'b000};
      sel  = wide[XLEN-1:0];
      case (f3)
         3'b000:  extract = {{24{sel[7]}}, sel[7:0]};
         3'b001:  extract = {{16{sel[15]}}, sel[15:0]};
         3'b100:  extract = {24'h0, sel[7:0]};
         3'b101:  extract = {16'h0, sel[15:0]};
         default: extract = sel;
      endcase
   endfunction

   assign legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);

   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      funct3_d   = funct3_q;
      split_d    = split_q;
      err_d      = err_q;
      word0_d    = word0_q;
      word1_d    = word1_q;
      rd_addr_d  = rd_addr_q;
      rd_valid_d = rd_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               off_d    = bus.req_addr[1:0];
               funct3_d = bus.req_funct3;
               split_d  = (3'(bus.req_addr[1:0]) + size) > 3'd4;
               err_d    = !legal;
               word0_d  = '0;
               word1_d  = '0;
               if (legal) begin
                  rd_addr_d  = {bus.req_addr[XLEN-1:2], 2'b00};
                  rd_valid_d = 1'b1;
                  state_d    = RD0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD0: begin
            if (bus.mem_rd_ready) begin
               rd_valid_d = 1'b0;
               state_d    = WAIT0;
            end
         end
         WAIT0: begin
            if (bus.mem_rsp_valid) begin
               word0_d = bus.mem_rsp_data;
               if (split_q) begin
                  // Address wraps modulo 2^32 for a straddle at the top of memory
                  rd_addr_d  = rd_addr_q + XLEN'(4);
                  rd_valid_d = 1'b1;
                  state_d    = RD1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD1: begin
            if (bus.mem_rd_ready) begin
               rd_valid_d = 1'b0;
               state_d    = WAIT1;
            end
         end
         WAIT1: begin
            if (bus.mem_rsp_valid) begin
               word1_d = bus.mem_rsp_data;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Result registers load on entry to DONE so they are valid exactly during DONE
      res_valid_d = (state_d == DONE);
      res_err_d   = (state_d == DONE) && err_d;
      res_data_d  = ((state_d == DONE) && !err_d) ? extract(funct3_d, off_d, word0_d, word1_d) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         off_q       <= '0;
         funct3_q    <= '0;
         split_q     <= 1'b0;
         err_q       <= 1'b0;
         word0_q     <= '0;
         word1_q     <= '0;
         rd_addr_q   <= '0;
         rd_valid_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         funct3_q    <= funct3_d;
         split_q     <= split_d;
         err_q       <= err_d;
         word0_q     <= word0_d;
         word1_q     <= word1_d;
         rd_addr_q   <= rd_addr_d;
         rd_valid_q  <= rd_valid_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
      end
   end

   assign bus.req_ready    = (state_q == IDLE) && reset_n;
   assign bus.mem_rd_valid = rd_valid_q;
   assign bus.mem_rd_addr  = rd_addr_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_err      = res_err_q;
endmodule
